// File: rtl/bitcell_nand.sv
// Single-bit storage cell with NAND-decoded set/clear write strobes,
// asynchronous reset and a combinational, select-gated read port.
module bitcell_nand #(
  parameter logic RESET_VALUE = 1'b0,
  parameter logic IDLE_OUT    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  input  logic r_w,
  input  logic sel,
  output logic out,
  output logic stored_value
);

  logic set_n;
  logic clear_n;
  logic bit_q;
  logic bit_d;

  assign set_n   = ~(sel & r_w & in);
  assign clear_n = ~(sel & r_w & ~in);

  // Set wins by construction (strobes are exclusive); written as a boolean
  // equation so an X on `in` during a write lands in the stored bit.
  always_comb begin
    bit_d = ~set_n | (clear_n & bit_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q <= RESET_VALUE;
    end else begin
      bit_q <= bit_d;
    end
  end

  always_comb begin
    out = IDLE_OUT;
    if (sel && !r_w) begin
      out = bit_q;
    end
  end

  assign stored_value = bit_q;

endmodule

// File: tb/tb_bitcell_nand.sv
// Bench for bitcell_nand: eight cells form a word sharing sel/r_w/rst;
// expectations are queued when stimulus is driven and popped when sampled.
module tb_bitcell_nand;

  logic       clk;
  logic       rst;
  logic       r_w;
  logic       sel;
  logic [7:0] in_bus;
  logic [7:0] out_bus;
  logic [7:0] sv_bus;

  typedef struct {
    string      name;
    logic [7:0] eout;
    logic [7:0] esv;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         checks;
  int         errors;
  logic [7:0] model;

  for (genvar g = 0; g < 8; g++) begin : g_cell
    bitcell_nand #(.RESET_VALUE(1'b0), .IDLE_OUT(1'b0)) u_cell (
      .clk          (clk),
      .rst          (rst),
      .in           (in_bus[g]),
      .r_w          (r_w),
      .sel          (sel),
      .out          (out_bus[g]),
      .stored_value (sv_bus[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_out(input logic s, input logic rw, input logic [7:0] m);
    return (s && !rw) ? m : 8'h00;
  endfunction

  task automatic drive(input logic s, input logic rw, input logic [7:0] d);
    sel = s;
    r_w = rw;
    in_bus = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    #2;
    model = 8'h00;
    sb.push_back('{"reset", 8'h00, 8'h00});
    e = sb.pop_front();
    checks++;
    if (out_bus !== e.eout) begin errors++; $display("FAIL %s out=%b expected %b", e.name, out_bus, e.eout); end
    checks++;
    if (sv_bus !== e.esv) begin errors++; $display("FAIL %s stored=%b expected %b", e.name, sv_bus, e.esv); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_deselected_write();
    @(negedge clk);
    drive(1'b0, 1'b1, 8'hFF);
    sb.push_back('{"desel_write", 8'h00, 8'h00});
    repeat (2) @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (out_bus !== e.eout) begin errors++; $display("FAIL %s out=%b expected %b", e.name, out_bus, e.eout); end
    checks++;
    if (sv_bus !== e.esv) begin errors++; $display("FAIL %s stored=%b expected %b", e.name, sv_bus, e.esv); end
  endtask

  task automatic test_read_ignores_in();
    @(negedge clk);
    drive(1'b1, 1'b0, 8'hFF);
    sb.push_back('{"read_ign_in", 8'h00, 8'h00});
    #1;
    e = sb.pop_front();
    checks++;
    if (out_bus !== e.eout) begin errors++; $display("FAIL %s out=%b expected %b", e.name, out_bus, e.eout); end
    checks++;
    if (sv_bus !== e.esv) begin errors++; $display("FAIL %s stored=%b expected %b", e.name, sv_bus, e.esv); end
    @(posedge clk);
    #1;
    checks++;
    if (sv_bus !== 8'h00) begin errors++; $display("FAIL read_no_modify stored=%b expected %b", sv_bus, 8'h00); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    drive(1'b1, 1'b1, 8'h01);
    #1;
    checks++;
    if (out_bus !== 8'h00) begin errors++; $display("FAIL write_no_thru out=%b expected %b", out_bus, 8'h00); end
    checks++;
    if (sv_bus !== 8'h00) begin errors++; $display("FAIL write_latency stored=%b expected %b", sv_bus, 8'h00); end
    model = 8'h01;
    sb.push_back('{"write_1", 8'h00, model});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (out_bus !== e.eout) begin errors++; $display("FAIL %s out=%b expected %b", e.name, out_bus, e.eout); end
    checks++;
    if (sv_bus !== e.esv) begin errors++; $display("FAIL %s stored=%b expected %b", e.name, sv_bus, e.esv); end
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h00);
    sb.push_back('{"read_1", model, model});
    #1;
    e = sb.pop_front();
    checks++;
    if (out_bus !== e.eout) begin errors++; $display("FAIL %s out=%b expected %b", e.name, out_bus, e.eout); end
    checks++;
    if (sv_bus !== e.esv) begin errors++; $display("FAIL %s stored=%b expected %b", e.name, sv_bus, e.esv); end
  endtask

  task automatic test_retention();
    @(negedge clk);
    drive(1'b0, 1'b0, 8'hFE);
    sb.push_back('{"retention", 8'h00, model});
    repeat (3) @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (out_bus !== e.eout) begin errors++; $display("FAIL %s out=%b expected %b", e.name, out_bus, e.eout); end
    checks++;
    if (sv_bus !== e.esv) begin errors++; $display("FAIL %s stored=%b expected %b", e.name, sv_bus, e.esv); end
    @(negedge clk);
    drive(1'b1, 1'b1, 8'h00);
    model = 8'h00;
    sb.push_back('{"clear", 8'h00, model});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (sv_bus !== e.esv) begin errors++; $display("FAIL %s stored=%b expected %b", e.name, sv_bus, e.esv); end
    @(negedge clk);
    drive(1'b1, 1'b0, 8'hFF);
    sb.push_back('{"read_clear", model, model});
    #1;
    e = sb.pop_front();
    checks++;
    if (out_bus !== e.eout) begin errors++; $display("FAIL %s out=%b expected %b", e.name, out_bus, e.eout); end
  endtask

  task automatic test_word_sweep();
    logic [7:0] pats [2];
    pats[0] = 8'b01010101;
    pats[1] = 8'b11001100;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, pats[i]);
      model = pats[i];
      sb.push_back('{"sweep_wr", 8'h00, model});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (sv_bus !== e.esv) begin errors++; $display("FAIL %s stored=%b expected %b", e.name, sv_bus, e.esv); end
      @(negedge clk);
      drive(1'b1, 1'b0, ~pats[i]);
      sb.push_back('{"sweep_rd", model, model});
      #1;
      e = sb.pop_front();
      checks++;
      if (out_bus !== e.eout) begin errors++; $display("FAIL %s out=%b expected %b", e.name, out_bus, e.eout); end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(1'b1, 1'b1, 8'hFF);
    @(posedge clk);
    #1;
    model = 8'hFF;
    checks++;
    if (sv_bus !== model) begin errors++; $display("FAIL pre_reset stored=%b expected %b", sv_bus, model); end
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h00);
    #1;
    rst = 1'b1;
    model = 8'h00;
    sb.push_back('{"async_rst", 8'h00, model});
    #1;
    e = sb.pop_front();
    checks++;
    if (sv_bus !== e.esv) begin errors++; $display("FAIL %s stored=%b expected %b", e.name, sv_bus, e.esv); end
    checks++;
    if (out_bus !== e.eout) begin errors++; $display("FAIL %s out=%b expected %b", e.name, out_bus, e.eout); end
    // reset held across an edge with a valid write strobe
    drive(1'b1, 1'b1, 8'hFF);
    sb.push_back('{"rst_dominates", 8'h00, model});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (sv_bus !== e.esv) begin errors++; $display("FAIL %s stored=%b expected %b", e.name, sv_bus, e.esv); end
    #2;
    rst = 1'b0;
    model = 8'hFF;
    sb.push_back('{"rst_release_wr", 8'h00, model});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (sv_bus !== e.esv) begin errors++; $display("FAIL %s stored=%b expected %b", e.name, sv_bus, e.esv); end
  endtask

  task automatic test_back_to_back();
    logic       s;
    logic       rw;
    logic [7:0] d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      s  = 1'($urandom_range(0, 3) != 0);
      rw = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      drive(s, rw, d);
      sb.push_back('{"b2b_comb", exp_out(s, rw, model), model});
      if (s && rw) model = d;
      sb.push_back('{"b2b_edge", exp_out(s, rw, model), model});
      #1;
      e = sb.pop_front();
      checks++;
      if (out_bus !== e.eout) begin errors++; $display("FAIL %s[%0d] out=%b expected %b", e.name, i, out_bus, e.eout); end
      checks++;
      if (sv_bus !== e.esv) begin errors++; $display("FAIL %s[%0d] stored=%b expected %b", e.name, i, sv_bus, e.esv); end
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (out_bus !== e.eout) begin errors++; $display("FAIL %s[%0d] out=%b expected %b", e.name, i, out_bus, e.eout); end
      checks++;
      if (sv_bus !== e.esv) begin errors++; $display("FAIL %s[%0d] stored=%b expected %b", e.name, i, sv_bus, e.esv); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    sel    = 1'b0;
    r_w    = 1'b0;
    in_bus = 8'h00;
    model  = 8'h00;
    test_reset();
    test_deselected_write();
    test_read_ignores_in();
    test_write_read();
    test_retention();
    test_word_sweep();
    test_async_reset();
    test_back_to_back();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected %0d", sb.size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
